// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants, control codes and FSM encoding for the ALU-control sequencer
package alu_ctrl_pkg;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [5:0] FUNCT_OP2 = 6'b000010;
  localparam logic [5:0] FUNCT_OP3 = 6'b000011;
  localparam logic [5:0] FUNCT_OP5 = 6'b000101;
  localparam logic [5:0] FUNCT_OP7 = 6'b000111;
  localparam logic [5:0] FUNCT_MULT_DEF = 6'b011000;
  localparam logic [5:0] FUNCT_DIV_DEF  = 6'b011010;

  localparam logic [2:0] CTR_OP2     = 3'b101;
  localparam logic [2:0] CTR_OP3     = 3'b110;
  localparam logic [2:0] CTR_OP5     = 3'b001;
  localparam logic [2:0] CTR_OP7     = 3'b100;
  localparam logic [2:0] CTR_DEFAULT = 3'b000;
  localparam logic [2:0] CTR_MD      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/alu_ctr_decode.sv
// rtl/alu_ctr_decode.sv - combinational ALUop/funct table producing alu_ctr and mul/div flags
module alu_ctr_decode
  import alu_ctrl_pkg::*;
#(
  parameter logic [5:0] FUNCT_MULT = FUNCT_MULT_DEF,
  parameter logic [5:0] FUNCT_DIV  = FUNCT_DIV_DEF
) (
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] ctr,
  output logic       is_md,
  output logic       is_div
);
  logic is_r;

  always_comb begin
    is_r   = (alu_op == ALUOP_RTYPE);
    is_md  = is_r && ((funct == FUNCT_MULT) || (funct == FUNCT_DIV));
    is_div = is_r && (funct == FUNCT_DIV);
    ctr    = alu_op;
    if (is_md) begin
      ctr = CTR_MD;
    end else if (is_r) begin
      case (funct)
        FUNCT_OP2: ctr = CTR_OP2;
        FUNCT_OP3: ctr = CTR_OP3;
        FUNCT_OP5: ctr = CTR_OP5;
        FUNCT_OP7: ctr = CTR_OP7;
        default:   ctr = CTR_DEFAULT;
      endcase
    end
  end
endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU-control decode with a start/step/done sequencer for mul/div
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int         MUL_CYCLES = 32,
  parameter int         DIV_CYCLES = 33,
  parameter logic [5:0] FUNCT_MULT = FUNCT_MULT_DEF,
  parameter logic [5:0] FUNCT_DIV  = FUNCT_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] ALUop,
  input  logic [5:0] function_code,
  input  logic       flush,
  output logic [2:0] alu_ctr,
  output logic       alu_ctr_valid,
  output logic       md_start,
  output logic       md_step,
  output logic       md_done,
  output logic       md_is_div,
  output logic       busy
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       dec_ctr;
  logic             dec_md, dec_div;
  logic             accept;

  alu_ctr_decode #(.FUNCT_MULT(FUNCT_MULT), .FUNCT_DIV(FUNCT_DIV)) u_decode (
    .alu_op (ALUop),
    .funct  (function_code),
    .ctr    (dec_ctr),
    .is_md  (dec_md),
    .is_div (dec_div)
  );

  // An op presented alongside flush belongs to the squashed path and is dropped.
  assign accept = op_valid && op_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: state_nxt = (accept && dec_md) ? ST_START : ST_IDLE;
        ST_START:         state_nxt = ST_RUN;
        ST_RUN:           state_nxt = (cnt == '0) ? ST_DONE : ST_RUN;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // Strobes are forced low while reset is asserted, even mid-operation.
  always_comb begin
    md_start = !reset && (state == ST_START);
    md_step  = !reset && (state == ST_RUN);
    md_done  = !reset && (state == ST_DONE);
    busy     = !reset && ((state == ST_START) || (state == ST_RUN));
    op_ready = !reset && ((state == ST_IDLE) || (state == ST_DONE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      alu_ctr       <= CTR_DEFAULT;
      alu_ctr_valid <= 1'b0;
      md_is_div     <= 1'b0;
    end else begin
      alu_ctr_valid <= 1'b0;
      if (!flush) begin
        if (accept) begin
          alu_ctr       <= dec_ctr;
          alu_ctr_valid <= !dec_md;
          if (dec_md) md_is_div <= dec_div;
        end
        if (state == ST_START)                cnt <= md_is_div ? DIV_LOAD : MUL_LOAD;
        else if (state == ST_RUN && cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end
endmodule
